// File: rtl/frame_cfg_pkg.sv
// Shared constants and state encoding for the frame configuration writer.
package frame_cfg_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hFAB0_FAB1;

    localparam int unsigned DESYNC_BIT = 31;
    localparam int unsigned COL_LSB    = 8;
    localparam int unsigned COL_MSB    = 15;
    localparam int unsigned FRAME_LSB  = 0;
    localparam int unsigned FRAME_MSB  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CHECK,
        STROBE
    } state_e;

endpackage

// File: rtl/frame_strobe_decode.sv
// One-hot decode of (column, frame) into the flat column-major FrameStrobe vector.
module frame_strobe_decode
    import frame_cfg_pkg::*;
#(
    parameter int unsigned NumColumns      = 4,
    parameter int unsigned MaxFramesPerCol = 32
) (
    input  logic [COL_MSB-COL_LSB:0]              col,
    input  logic [FRAME_MSB-FRAME_LSB:0]          frame,
    input  logic                                  en,
    output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

    always_comb begin
        strobe = '0;
        for (int unsigned c = 0; c < NumColumns; c++) begin
            for (int unsigned f = 0; f < MaxFramesPerCol; f++) begin
                strobe[c*MaxFramesPerCol+f] = en && (32'(col) == c) && (32'(frame) == f);
            end
        end
    end

endmodule

// File: rtl/frame_config_writer.sv
// Frame configuration writer: sync/address/data stream to FrameData + one-hot FrameStrobe.
// Define FRAME_CONFIG_WRITER_CHECKSUM_EN to require an XOR checksum word after each frame.
module frame_config_writer
    import frame_cfg_pkg::*;
#(
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 32,
    parameter int unsigned NumRows         = 4,
    parameter int unsigned NumColumns      = 4,
    parameter int unsigned StrobeCycles    = 2
) (
    input  logic                                  UserCLK,
    input  logic                                  Reset,
    input  logic [FrameBitsPerRow-1:0]            cfg_data,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  frame_err,
    output logic [15:0]                           frames_written
);

    localparam int unsigned RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int unsigned CntW = $clog2(StrobeCycles + 1);
    localparam logic [RowW-1:0] RowLast   = RowW'(NumRows - 1);
    localparam logic [CntW-1:0] StrobeEnd = CntW'(StrobeCycles);

    typedef logic [NumRows-1:0][FrameBitsPerRow-1:0] frame_t;

    state_e                       state_q, state_d;
    logic [RowW-1:0]              row_q, row_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [COL_MSB-COL_LSB:0]     col_q, col_d;
    logic [FRAME_MSB-FRAME_LSB:0] frm_q, frm_d;
    logic                         drop_q, drop_d;
    logic                         err_q, err_d;
    logic [15:0]                  count_q, count_d;
    frame_t                       shadow_q, shadow_d;
    frame_t                       fdata_q, fdata_d;
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0]   csum_q, csum_d;
`endif

    logic xfer;
    logic addr_bad;
    logic strobe_en;

    assign cfg_ready      = !Reset && (state_q != STROBE);
    assign xfer           = cfg_valid && cfg_ready;
    assign busy           = (state_q != IDLE);
    assign frame_err      = err_q;
    assign frames_written = count_q;
    assign FrameData      = fdata_q;

    assign addr_bad = (32'(cfg_data[COL_MSB:COL_LSB]) >= NumColumns) ||
                      (32'(cfg_data[FRAME_MSB:FRAME_LSB]) >= MaxFramesPerCol);

    // Cycle 0 of STROBE loads FrameData; the strobe itself covers cycles 1..StrobeCycles.
    assign strobe_en = (state_q == STROBE) && !drop_q && (cnt_q != '0);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        frm_d    = frm_q;
        drop_d   = drop_q;
        err_d    = err_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        fdata_d  = fdata_q;
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer && (cfg_data == SYNC_WORD)) begin
                    err_d   = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (xfer) begin
                    if (cfg_data[DESYNC_BIT]) begin
                        state_d = IDLE;
                    end else begin
                        col_d   = cfg_data[COL_MSB:COL_LSB];
                        frm_d   = cfg_data[FRAME_MSB:FRAME_LSB];
                        drop_d  = addr_bad;
                        err_d   = err_q | addr_bad;
                        row_d   = '0;
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
                        csum_d  = cfg_data;
`endif
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    shadow_d[row_q] = cfg_data;
                    row_d           = row_q + RowW'(1);
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
                    csum_d          = csum_q ^ cfg_data;
`endif
                    if (row_q == RowLast) begin
                        cnt_d   = '0;
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = STROBE;
`endif
                    end
                end
            end
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    if (cfg_data != csum_q) begin
                        err_d  = 1'b1;
                        drop_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = STROBE;
                end
            end
`endif
            STROBE: begin
                if (drop_q) begin
                    state_d = ADDR;
                end else begin
                    if (cnt_q == '0) begin
                        fdata_d = shadow_q;
                    end
                    if (cnt_q == StrobeEnd) begin
                        count_d = count_q + 16'd1;
                        state_d = ADDR;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            cnt_q    <= '0;
            col_q    <= '0;
            frm_q    <= '0;
            drop_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            shadow_q <= '0;
            fdata_q  <= '0;
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            frm_q    <= frm_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            fdata_q  <= fdata_d;
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    frame_strobe_decode #(
        .NumColumns      (NumColumns),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_strobe_decode (
        .col    (col_q),
        .frame  (frm_q),
        .en     (strobe_en),
        .strobe (FrameStrobe)
    );

endmodule

// File: tb/tb_frame_config_writer.sv
// Scoreboard bench for frame_config_writer: driver queues expected strobes, monitor checks them.
module tb_frame_config_writer;

    localparam int unsigned NumRows    = 4;
    localparam int unsigned NumColumns = 4;
    localparam int unsigned MaxFrames  = 32;
    localparam int unsigned NumStrobe  = NumColumns * MaxFrames;

    logic                  UserCLK = 1'b0;
    logic                  Reset;
    logic [31:0]           cfg_data;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [127:0]          FrameData;
    logic [NumStrobe-1:0]  FrameStrobe;
    logic                  busy;
    logic                  frame_err;
    logic [15:0]           frames_written;

    frame_config_writer #(
        .FrameBitsPerRow (32),
        .MaxFramesPerCol (MaxFrames),
        .NumRows         (NumRows),
        .NumColumns      (NumColumns),
        .StrobeCycles    (2)
    ) dut (
        .UserCLK        (UserCLK),
        .Reset          (Reset),
        .cfg_data       (cfg_data),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .FrameData      (FrameData),
        .FrameStrobe    (FrameStrobe),
        .busy           (busy),
        .frame_err      (frame_err),
        .frames_written (frames_written)
    );

    always #5 UserCLK = ~UserCLK;

    typedef struct {
        int           idx;
        logic [127:0] data;
        int           len;
        int           cnt;
        int           start;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;

    always @(posedge UserCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expected entry per strobe pulse.
    exp_t cur;
    bit   in_pulse = 1'b0;
    int   plen = 0;
    int   act_idx;

    always @(negedge UserCLK) begin
        if (FrameStrobe != '0) begin
            act_idx = -1;
            for (int i = 0; i < int'(NumStrobe); i++) if (FrameStrobe[i]) act_idx = i;
            check("strobe_onehot", 128'($onehot(FrameStrobe)), 128'd1);
            check("ready_low_in_strobe", 128'(cfg_ready), 128'd0);
            if (!in_pulse) begin
                in_pulse = 1'b1;
                plen     = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: bit %0d high, required no strobe", act_idx);
                    cur = '{idx: -1, data: '0, len: 0, cnt: 0, start: 0};
                end else begin
                    cur = exp_q.pop_front();
                    check("strobe_start_cycle", 128'(cyc), 128'(cur.start));
                end
            end else begin
                plen++;
            end
            check("strobe_index", 128'(act_idx), 128'(cur.idx));
            check("strobe_framedata", FrameData, cur.data);
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            check("strobe_length", 128'(plen), 128'(cur.len));
            check("frames_written_after_strobe", 128'(frames_written), 128'(cur.cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge UserCLK);
        #1;
    endtask

    // Driven at posedge+1; the word is accepted at the next posedge when cfg_ready is high.
    task automatic send_word(input logic [31:0] w, input bit gaps);
        int n;
        if (gaps) begin
            cfg_valid = 1'b0;
            step(int'($urandom_range(0, 3)));
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 100) begin
            step(1);
            n++;
        end
        if (!cfg_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cfg_ready 0 for 100 cycles, required 1");
        end
        last_acc = cyc;
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input bit gaps,
                              input bit bad_sum, input bit exp_strobe, input int exp_idx,
                              input int exp_len, input int exp_cnt);
        exp_t e;
        send_word(addr, gaps);
        send_word(d0, gaps);
        send_word(d1, gaps);
        send_word(d2, gaps);
        send_word(d3, gaps);
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
        begin
            logic [31:0] sum;
            sum = addr ^ d0 ^ d1 ^ d2 ^ d3;
            if (bad_sum) sum = sum + 32'd1;
            send_word(sum, gaps);
        end
`endif
        if (exp_strobe && !bad_sum) begin
            e = '{idx: exp_idx, data: {d3, d2, d1, d0}, len: exp_len, cnt: exp_cnt,
                  start: last_acc + 2};
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        step(3);
        check("ready_in_reset", 128'(cfg_ready), 128'd0);
        Reset = 1'b0;
        step(1);
        check("reset_framedata", FrameData, 128'd0);
        check("reset_strobe", 128'(FrameStrobe), 128'd0);
        check("reset_ready", 128'(cfg_ready), 128'd1);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_err", 128'(frame_err), 128'd0);
        check("reset_count", 128'(frames_written), 128'd0);

        // Basic frame to column 2, frame 3.
        send_word(32'h1234_5678, 1'b0);
        check("junk_ignored_busy", 128'(busy), 128'd0);
        send_word(32'hFAB0_FAB1, 1'b0);
        check("sync_busy", 128'(busy), 128'd1);
        send_frame(32'h0000_0203, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 1'b0, 1'b1, 67, 2, 1);
        step(5);
        check("f1_framedata", FrameData, 128'h00000044_00000033_00000022_00000011);
        check("f1_count", 128'(frames_written), 128'd1);
        check("f1_err", 128'(frame_err), 128'd0);

        // Column 5 is out of range: dropped, sticky error.
        send_frame(32'h0000_0500, 32'h55, 32'h66, 32'h77, 32'h88, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        step(5);
        check("drop_err", 128'(frame_err), 128'd1);
        check("drop_framedata", FrameData, 128'h00000044_00000033_00000022_00000011);
        check("drop_count", 128'(frames_written), 128'd1);
        send_word(32'h8000_0000, 1'b0);
        check("desync_busy", 128'(busy), 128'd0);
        check("err_sticky_idle", 128'(frame_err), 128'd1);
        send_word(32'hFAB0_FAB1, 1'b0);
        check("sync_clears_err", 128'(frame_err), 128'd0);

        // Stalls between words must not change data or timing.
        send_frame(32'h0000_0105, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF,
                   1'b1, 1'b0, 1'b1, 37, 2, 2);
        step(5);
        check("gap_framedata", FrameData, 128'h89ABCDEF_01234567_CAFEF00D_DEADBEEF);

`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
        send_frame(32'h0000_0002, 32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 1'b1, 1'b1, 2, 2, 3);
        step(5);
        check("bad_sum_err", 128'(frame_err), 128'd1);
        check("bad_sum_count", 128'(frames_written), 128'd2);
`endif

        // Reset during the second strobe cycle.
        send_frame(32'h0000_0300, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 1'b0, 1'b0, 1'b1, 96, 2, 0);
        step(2);
        Reset = 1'b1;
        #0;
        check("ready_low_on_reset", 128'(cfg_ready), 128'd0);
        step(1);
        check("rst_strobe_drop", 128'(FrameStrobe), 128'd0);
        check("rst_framedata", FrameData, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ready", 128'(cfg_ready), 128'd0);
        Reset = 1'b0;
        step(1);
        check("rst_count", 128'(frames_written), 128'd0);

        // Words before sync are ignored; two back-to-back frames then desync.
        send_word(32'hFAB0_FAB0, 1'b0);
        send_word(32'h0000_0203, 1'b0);
        check("pre_sync_idle", 128'(busy), 128'd0);
        send_word(32'hFAB0_FAB1, 1'b0);
        send_frame(32'h0000_0001, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 1'b0, 1'b0, 1'b1, 1, 2, 1);
        send_frame(32'h0000_031F, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 1'b0, 1'b0, 1'b1, 127, 2, 2);
        send_word(32'h8000_0000, 1'b0);
        step(4);
        check("b2b_count", 128'(frames_written), 128'd2);
        check("b2b_busy", 128'(busy), 128'd0);
        check("b2b_framedata", FrameData, 128'h000000C4_000000C3_000000C2_000000C1);
        check("pending_strobes", 128'(exp_q.size()), 128'd0);
        check("pulse_closed", 128'(in_pulse), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
